// File: rtl/mem_arb_pkg.sv
// Shared constants and state encoding for the memory fill arbiter.
package mem_arb_pkg;

  localparam int unsigned BLK_WORDS = 8;
  localparam int unsigned MEM_LAT   = 4;
  localparam int unsigned CNT_W     = $clog2(BLK_WORDS);

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFillI = 2'd1,
    StFillD = 2'd2,
    StWrite = 2'd3
  } arb_state_e;

endpackage

// File: rtl/fill_counter.sv
// Word counter for one block transaction: counts 0..BLK_WORDS-1, then sets a
// terminal flag and holds until cleared, so it never wraps into a ninth word.
module fill_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_term
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_term;

  // Count enabled words; the terminal flag freezes the count after the last word.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt  <= '0;
      r_term <= 1'b0;
    end else if (i_en && !r_term) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CNT_W'(BLK_WORDS - 1)) begin
        r_term <= 1'b1;
      end
    end
  end

  assign o_count = r_cnt;
  assign o_term  = r_term;

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates I/D block fills and D-side write-through stores onto one pipelined
// memory port, streams fill words back to the caches and drives pipeline stalls.
module mem_fill_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss_req,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss_req,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_valid,
  output logic [DATA_W-1:0] fill_data,
  output logic [CNT_W-1:0]  fill_word,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_ack,
  output logic              istall,
  output logic              dstall
);

  // Byte-offset bits inside a block (16 bytes -> low 4 bits).
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(2 * BLK_WORDS - 1);

  arb_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base, w_base_nxt;
  logic              r_owner, w_owner_nxt;

  logic             w_cnt_clr;
  logic             w_ic_en, w_rc_en;
  logic [CNT_W-1:0] w_ic, w_rc;
  logic             w_ic_term, w_rc_term;
  logic             w_rc_last;
  logic             w_we;

  assign w_cnt_clr = (r_state == StIdle);
  assign w_rc_last = (w_rc == CNT_W'(BLK_WORDS - 1)) && !w_rc_term;

  fill_counter u_issue_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_cnt_clr),
    .i_en    (w_ic_en),
    .o_count (w_ic),
    .o_term  (w_ic_term)
  );

  fill_counter u_recv_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_cnt_clr),
    .i_en    (w_rc_en),
    .o_count (w_rc),
    .o_term  (w_rc_term)
  );

  // State, block base and owner registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_base  <= '0;
      r_owner <= OWNER_I;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // Next-state decision, memory port drive and fill-return decode.
  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_owner_nxt = r_owner;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    w_ic_en     = 1'b0;
    w_rc_en     = 1'b0;
    w_we        = 1'b0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;

    unique case (r_state)
      StIdle: begin
        // Fixed priority: I miss, then D miss, then store.
        if (i_miss_req) begin
          w_state_nxt = StFillI;
          w_base_nxt  = i_miss_addr & ~BLK_MASK;
          w_owner_nxt = OWNER_I;
        end else if (d_miss_req) begin
          w_state_nxt = StFillD;
          w_base_nxt  = d_miss_addr & ~BLK_MASK;
          w_owner_nxt = OWNER_D;
        end else if (d_wr_req) begin
          w_state_nxt = StWrite;
        end
      end

      StFillI, StFillD: begin
        if (!w_ic_term) begin
          mem_enable = 1'b1;
          mem_addr   = r_base | ADDR_W'({w_ic, 1'b0});
          w_ic_en    = 1'b1;
        end
        // Words past the eighth are dropped so a stray valid cannot corrupt the cache.
        if (mem_data_valid && !w_rc_term) begin
          w_rc_en = 1'b1;
          w_we    = 1'b1;
          if (w_rc_last) begin
            w_state_nxt = StIdle;
            i_fill_done = (r_owner == OWNER_I);
            d_fill_done = (r_owner == OWNER_D);
          end
        end
        i_fill_we = w_we && (r_owner == OWNER_I);
        d_fill_we = w_we && (r_owner == OWNER_D);
      end

      StWrite: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = d_wr_addr;
        mem_wdata   = d_wr_data;
        d_wr_ack    = 1'b1;
        w_state_nxt = StIdle;
      end

      default: w_state_nxt = StIdle;
    endcase
  end

  assign fill_data = mem_rdata;
  assign fill_word = w_rc;

  // A D request being retired this cycle no longer holds the pipeline; a store
  // still waiting behind a D fill keeps dstall up.
  assign istall = i_miss_req || (r_state == StFillI);
  assign dstall = ((d_miss_req || (r_state == StFillD)) && !d_fill_done)
               || (d_wr_req && !d_wr_ack);

endmodule
